// File: rtl/vga_rect_filler.sv
// Rectangle-fill engine feeding the VGA video-memory write port, one pixel per cycle in raster order.
// Optional clipping to the visible screen is enabled by defining VGA_RECT_CLIP_EN.
module vga_rect_filler #(
  parameter string RESOLUTION              = "320x240",
  parameter int    BITS_PER_COLOUR_CHANNEL = 1,
  parameter string MONOCHROME              = "FALSE",
  localparam int   XW = (RESOLUTION == "160x120") ? 8 : 9,
  localparam int   YW = (RESOLUTION == "160x120") ? 7 : 8,
  localparam int   CW = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_h,
  input  logic [CW-1:0] cmd_colour,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  input  logic          plot_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  // Counters carry one extra bit so the end comparison is exact even when the
  // visible coordinate wraps past 2^XW / 2^YW.
  logic [XW:0]   x_q, x_d;
  logic [XW:0]   x_start_q, x_start_d;
  logic [XW:0]   x_end_q, x_end_d;
  logic [YW:0]   y_q, y_d;
  logic [YW:0]   y_end_q, y_end_d;
  logic [CW-1:0] colour_q, colour_d;

  logic [XW:0]   acc_x_end;
  logic [YW:0]   acc_y_end;
  logic          acc_empty;
  logic [XW:0]   x_inc;
  logic [YW:0]   y_inc;
  logic          row_end;
  logic          last_pixel;

`ifdef VGA_RECT_CLIP_EN
  localparam int          SCREEN_W   = (RESOLUTION == "160x120") ? 160 : 320;
  localparam int          SCREEN_H   = (RESOLUTION == "160x120") ? 120 : 240;
  localparam logic [XW:0] SCREEN_W_V = SCREEN_W[XW:0];
  localparam logic [YW:0] SCREEN_H_V = SCREEN_H[YW:0];
`endif

  always_comb begin
    acc_x_end = {1'b0, cmd_x} + {1'b0, cmd_w};
    acc_y_end = {1'b0, cmd_y} + {1'b0, cmd_h};
    acc_empty = (cmd_w == '0) || (cmd_h == '0);
`ifdef VGA_RECT_CLIP_EN
    if (acc_x_end > SCREEN_W_V) acc_x_end = SCREEN_W_V;
    if (acc_y_end > SCREEN_H_V) acc_y_end = SCREEN_H_V;
    acc_empty = acc_empty || ({1'b0, cmd_x} >= SCREEN_W_V) || ({1'b0, cmd_y} >= SCREEN_H_V);
`endif
  end

  always_comb begin
    x_inc      = x_q + 1'b1;
    y_inc      = y_q + 1'b1;
    row_end    = (x_inc >= x_end_q);
    last_pixel = row_end && (y_inc >= y_end_q);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    x_start_d = x_start_q;
    x_end_d   = x_end_q;
    y_d       = y_q;
    y_end_d   = y_end_q;
    colour_d  = colour_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x_d       = {1'b0, cmd_x};
          x_start_d = {1'b0, cmd_x};
          x_end_d   = acc_x_end;
          y_d       = {1'b0, cmd_y};
          y_end_d   = acc_y_end;
          colour_d  = cmd_colour;
          state_d   = acc_empty ? DONE : FILL;
        end
      end
      FILL: begin
        if (plot_ready) begin
          if (last_pixel) begin
            state_d = DONE;
          end else if (row_end) begin
            x_d = x_start_q;
            y_d = y_inc;
          end else begin
            x_d = x_inc;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      x_q       <= '0;
      x_start_q <= '0;
      x_end_q   <= '0;
      y_q       <= '0;
      y_end_q   <= '0;
      colour_q  <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      x_start_q <= x_start_d;
      x_end_q   <= x_end_d;
      y_q       <= y_d;
      y_end_q   <= y_end_d;
      colour_q  <= colour_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign plot      = (state_q == FILL);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign x         = x_q[XW-1:0];
  assign y         = y_q[YW-1:0];
  assign colour    = colour_q;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Table-driven self-checking bench for vga_rect_filler (default 320x240, 3-bit colour).
module tb_vga_rect_filler;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x = '0;
  logic [YW-1:0] cmd_y = '0;
  logic [XW-1:0] cmd_w = '0;
  logic [YW-1:0] cmd_h = '0;
  logic [CW-1:0] cmd_colour = '0;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;
  logic          plot_ready = 1'b1;
  logic          busy;
  logic          done;

  vga_rect_filler dut (
    .clock      (clock),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_colour (cmd_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .plot_ready (plot_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int w;
    int h;
    int col;
    int stall;   // 0: plot_ready always 1, 1: pattern 1,0,0 repeating
    int exp_n;
    int last_x;
    int last_y;
  } vec_t;

  vec_t tbl[9];

  task automatic run_vec(input vec_t v, input int idx);
    int qx[$];
    int qy[$];
    int got, gap, pc, budget, lx, ly;
    bit seen_done, prev_stall;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [CW-1:0] pcol;
    got = 0; gap = 0; pc = 0; lx = 0; ly = 0;
    seen_done = 0; prev_stall = 0;
    px = '0; py = '0; pcol = '0;
    for (int j = 0; j < v.h; j++) begin
      for (int i = 0; i < v.w; i++) begin
        int ax, ay;
        ax = v.x + i;
        ay = v.y + j;
`ifdef VGA_RECT_CLIP_EN
        if (ax >= 320 || ay >= 240) continue;
`endif
        qx.push_back(ax % 512);
        qy.push_back(ay % 256);
      end
    end
    budget = v.w * v.h * 3 + 8;

    @(negedge clock);
    cmd_x = XW'(v.x); cmd_y = YW'(v.y); cmd_w = XW'(v.w); cmd_h = YW'(v.h);
    cmd_colour = CW'(v.col); cmd_valid = 1'b1; plot_ready = 1'b1;
    chk("accept_ready", cmd_ready, 1);
    @(negedge clock);
    cmd_valid = 1'b0;

    for (int c = 0; c < budget && !seen_done; c++) begin
      gap++;
      if (done) begin
        seen_done = 1;
        chk("done_plot_low", plot, 0);
        chk("done_latency", gap, 1);
      end else begin
        chk("plot_or_done", plot, 1);
        if (plot) begin
          chk("busy_in_fill", busy, 1);
          chk("ready_low_in_fill", cmd_ready, 0);
          chk("colour", colour, v.col);
          if (prev_stall) begin
            chk("hold_x", x, px);
            chk("hold_y", y, py);
            chk("hold_colour", colour, pcol);
          end
          plot_ready = (v.stall == 0) || (pc % 3 == 0);
          pc++;
          if (plot_ready) begin
            chk("pixel_expected", qx.size() > 0, 1);
            if (qx.size() > 0) begin
              chk("pixel_x", x, qx.pop_front());
              chk("pixel_y", y, qy.pop_front());
            end
            got++; lx = x; ly = y; gap = 0;
          end
          prev_stall = !plot_ready;
          px = x; py = y; pcol = colour;
        end
      end
      if (!seen_done) @(negedge clock);
    end
    if (!seen_done) chk("done_timeout", seen_done, 1);
    chk("pixel_count", got, v.exp_n);
    chk("model_drained", qx.size(), 0);
    if (v.exp_n > 0) begin
      chk("last_x", lx, v.last_x);
      chk("last_y", ly, v.last_y);
    end
    @(negedge clock);
    chk("post_done_low", done, 0);
    chk("post_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);
    plot_ready = 1'b1;
    $display("vec %0d: cmd (%0d,%0d) %0dx%0d col=%0d stall=%0d -> %0d pixels, last (%0d,%0d)",
             idx, v.x, v.y, v.w, v.h, v.col, v.stall, got, lx, ly);
  endtask

  initial begin
    tbl[0] = '{10, 20, 3, 2, 5, 0, 6, 12, 21};
    tbl[1] = '{10, 20, 3, 2, 5, 1, 6, 12, 21};
    tbl[2] = '{5, 7, 0, 5, 2, 0, 0, 0, 0};
    tbl[3] = '{1, 1, 4, 0, 1, 0, 0, 0, 0};
`ifdef VGA_RECT_CLIP_EN
    tbl[4] = '{318, 238, 4, 4, 4, 0, 4, 319, 239};
    tbl[5] = '{510, 0, 4, 1, 3, 0, 0, 0, 0};
`else
    tbl[4] = '{318, 238, 4, 4, 4, 0, 16, 321, 241};
    tbl[5] = '{510, 0, 4, 1, 3, 0, 4, 1, 0};
`endif
    tbl[6] = '{0, 0, 1, 1, 7, 0, 1, 0, 0};
    tbl[7] = '{100, 50, 1, 3, 2, 1, 3, 100, 52};
    tbl[8] = '{0, 0, 320, 240, 0, 0, 76800, 319, 239};

    #1 resetn = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    for (int k = 0; k < 9; k++) run_vec(tbl[k], k);

    // cmd_valid held high: ignored while busy, next accept in the cycle after done
    @(negedge clock);
    cmd_x = 9'd2; cmd_y = 8'd3; cmd_w = 9'd2; cmd_h = 8'd1; cmd_colour = 3'd6;
    cmd_valid = 1'b1; plot_ready = 1'b1;
    @(negedge clock);
    chk("hv_p0_plot", plot, 1); chk("hv_p0_x", x, 2); chk("hv_p0_y", y, 3);
    @(negedge clock);
    chk("hv_p1_plot", plot, 1); chk("hv_p1_x", x, 3); chk("hv_p1_y", y, 3);
    @(negedge clock);
    chk("hv_done", done, 1); chk("hv_done_ready", cmd_ready, 0); chk("hv_done_plot", plot, 0);
    @(negedge clock);
    chk("hv_idle_ready", cmd_ready, 1); chk("hv_idle_done", done, 0); chk("hv_idle_plot", plot, 0);
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("hv_re_plot", plot, 1); chk("hv_re_x", x, 2); chk("hv_re_colour", colour, 6);
    for (int c = 0; c < 10 && !done; c++) @(negedge clock);
    chk("hv_re_done", done, 1);
    @(negedge clock);
    $display("seq held_valid: back-to-back command accepted one cycle after done");

    // asynchronous reset after 3 of 6 pixels abandons the command
    cmd_x = 9'd10; cmd_y = 8'd20; cmd_w = 9'd3; cmd_h = 8'd2; cmd_colour = 3'd5;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("rm_mid_plot", plot, 1); chk("rm_mid_x", x, 10); chk("rm_mid_y", y, 21);
    resetn = 1'b0;
    #1;
    chk("rm_plot", plot, 0); chk("rm_ready", cmd_ready, 1); chk("rm_busy", busy, 0);
    chk("rm_x", x, 0); chk("rm_y", y, 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("rm_after_plot", plot, 0);
      chk("rm_after_done", done, 0);
    end
    $display("seq reset_mid_fill: command abandoned after 3 pixels");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
